// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types and constants for the two-port cache arbiter.
//   - arb_state_t : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   - *_DEF       : default widths / latency used by cache_arbiter parameters
//   - cache_req_t : request bundle {index, tag, data, mode} at default widths
//   - lat_done()  : terminal-count compare for the cache latency counter
package cache_arb_pkg;

  localparam int IDX_W_DEF     = 2;
  localparam int TAG_W_DEF     = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int CACHE_LAT_DEF = 1;
  localparam int LAT_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0]  index;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
    logic                  mode;   // 1 = write, 0 = read
  } cache_req_t;

  // True on the last WAIT cycle; the counter starts at 0 in the first WAIT cycle.
  function automatic logic lat_done(input logic [LAT_CNT_W-1:0] cnt,
                                    input int unsigned          lat);
    return cnt == LAT_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-requester grant.
// Ports:
//   valid0, valid1 : request valids from port 0 / port 1
//   last_grant     : port that won the previous accept (0 or 1)
//   grant0, grant1 : one-hot (or zero) grant
// Build option: CACHE_ARB_RR_EN defined -> a conflict goes to the port that
// did not win last time; undefined -> port 0 always wins a conflict and
// last_grant is ignored.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

`ifndef CACHE_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
`ifdef CACHE_ARB_RR_EN
      if (last_grant) grant0 = 1'b1;
      else            grant1 = 1'b1;
`else
      grant0 = 1'b1;
`endif
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: two-port access arbiter / sequencer in front of the 2-way
// set-associative cache. One request at a time is issued to the cache, the
// cache latency is waited out, and c_rdata is returned on a tagged response.
//
// Ports:
//   clock, reset_n                 : clock, async active-low reset
//   rN_valid/rN_ready              : request handshake, port N (N = 0, 1)
//   rN_index/tag/data/mode         : request fields (mode 1 = write)
//   rsp_valid/rsp_ready            : response handshake
//   rsp_id, rsp_data               : originating port, captured cache data
//   c_en                           : one-cycle access strobe (ISSUE)
//   c_index/c_tag/c_data/c_mode    : cache inputs, held until next accept
//   c_rdata                        : cache data_out
//
// Build option: CACHE_ARB_RR_EN (round-robin on conflict; else port 0 priority).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready offered to the granted port; accept latches the request
// ISSUE | c_en high, cache inputs driven from the hold register
// WAIT  | lat_cnt counts cache latency; c_rdata captured on last cycle
// RESP  | rsp_valid held with stable id/data until rsp_ready
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int IDX_W     = IDX_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CACHE_LAT = CACHE_LAT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [IDX_W-1:0]  r0_index,
  input  logic [TAG_W-1:0]  r0_tag,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r0_mode,

  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [IDX_W-1:0]  r1_index,
  input  logic [TAG_W-1:0]  r1_tag,
  input  logic [DATA_W-1:0] r1_data,
  input  logic              r1_mode,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,

  output logic              c_en,
  output logic [IDX_W-1:0]  c_index,
  output logic [TAG_W-1:0]  c_tag,
  output logic [DATA_W-1:0] c_data,
  output logic              c_mode,
  input  logic [DATA_W-1:0] c_rdata
);

  arb_state_t           state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q;
  logic                 last_grant_q;
  logic                 hold_id_q;
  logic                 grant0, grant1;
  logic                 accept;
  logic                 lat_last;

  rr_arbiter2 u_arb (
    .valid0     (r0_valid),
    .valid1     (r1_valid),
    .last_grant (last_grant_q),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign r0_ready  = (state_q == ST_IDLE) && grant0;
  assign r1_ready  = (state_q == ST_IDLE) && grant1;
  assign accept    = (r0_valid && r0_ready) || (r1_valid && r1_ready);
  assign lat_last  = lat_done(lat_cnt_q, CACHE_LAT);
  assign c_en      = (state_q == ST_ISSUE);
  assign rsp_valid = (state_q == ST_RESP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_ISSUE;
      ST_ISSUE:                state_d = ST_WAIT;
      ST_WAIT:  if (lat_last)  state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // The c_* outputs double as the hold register: they are loaded on accept
  // and stay put until the next accept, so the cache sees stable inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      hold_id_q    <= 1'b0;
      c_index      <= '0;
      c_tag        <= '0;
      c_data       <= '0;
      c_mode       <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        c_index      <= grant1 ? r1_index : r0_index;
        c_tag        <= grant1 ? r1_tag   : r0_tag;
        c_data       <= grant1 ? r1_data  : r0_data;
        c_mode       <= grant1 ? r1_mode  : r0_mode;
        hold_id_q    <= grant1;
        last_grant_q <= grant1;
      end

      if (state_q == ST_WAIT) begin
        if (lat_last) begin
          lat_cnt_q <= '0;
          rsp_data  <= c_rdata;
          rsp_id    <= hold_id_q;
        end else begin
          lat_cnt_q <= lat_cnt_q + LAT_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: self-checking bench for cache_arbiter (CACHE_LAT=1 main
// instance plus a CACHE_LAT=3 instance). Build option CACHE_ARB_RR_EN selects
// round-robin vs fixed-priority expectations.
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;
`ifdef CACHE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  // main instance
  logic       r0_valid, r0_ready, r0_mode, r1_valid, r1_ready, r1_mode;
  logic [1:0] r0_index, r1_index;
  logic [7:0] r0_tag, r0_data, r1_tag, r1_data;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
  logic       c_en, c_mode;
  logic [1:0] c_index;
  logic [7:0] c_tag, c_data, c_rdata;

  // cache model: a write echoes the written data, a read returns the tag
  assign c_rdata = c_mode ? c_data : c_tag;

  cache_arbiter #(.IDX_W(2), .TAG_W(8), .DATA_W(8), .CACHE_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_index(r0_index),
    .r0_tag(r0_tag), .r0_data(r0_data), .r0_mode(r0_mode),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_index(r1_index),
    .r1_tag(r1_tag), .r1_data(r1_data), .r1_mode(r1_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .c_en(c_en), .c_index(c_index), .c_tag(c_tag),
    .c_data(c_data), .c_mode(c_mode), .c_rdata(c_rdata)
  );

  // CACHE_LAT=3 instance, port 0 only, c_rdata driven directly by the bench
  logic       r0_valid_3, r0_ready_3, r1_ready_3, rsp_valid_3, rsp_ready_3, rsp_id_3;
  logic       c_en_3, c_mode_3;
  logic [1:0] c_index_3;
  logic [7:0] c_tag_3, c_data_3, c_rdata_3, rsp_data_3;
  logic       tie0_1b;
  logic [1:0] tie0_2b;
  logic [7:0] tie0_8b;
  assign tie0_1b = 1'b0;
  assign tie0_2b = 2'd0;
  assign tie0_8b = 8'd0;

  cache_arbiter #(.IDX_W(2), .TAG_W(8), .DATA_W(8), .CACHE_LAT(LAT3)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .r0_valid(r0_valid_3), .r0_ready(r0_ready_3), .r0_index(2'd1),
    .r0_tag(8'h42), .r0_data(8'h00), .r0_mode(1'b0),
    .r1_valid(tie0_1b), .r1_ready(r1_ready_3), .r1_index(tie0_2b),
    .r1_tag(tie0_8b), .r1_data(tie0_8b), .r1_mode(tie0_1b),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_id(rsp_id_3),
    .rsp_data(rsp_data_3), .c_en(c_en_3), .c_index(c_index_3), .c_tag(c_tag_3),
    .c_data(c_data_3), .c_mode(c_mode_3), .c_rdata(c_rdata_3)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       id;
    logic [7:0] data;
  } exp_rsp_t;

  // requester-side rule: valid and fields hold until ready
  logic       p_v0, p_rdy0, p_v1, p_rdy1;
  logic [18:0] p_f0, p_f1;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_v0 <= 1'b0; p_rdy0 <= 1'b0; p_v1 <= 1'b0; p_rdy1 <= 1'b0;
      p_f0 <= '0;   p_f1 <= '0;
    end else begin
      if (p_v0 && !p_rdy0) begin
        checks++;
        assert (r0_valid && {r0_index, r0_tag, r0_data, r0_mode} == p_f0)
        else begin errors++; $error("FAIL hold_stable_0: valid=%b expected held request", r0_valid); end
      end
      if (p_v1 && !p_rdy1) begin
        checks++;
        assert (r1_valid && {r1_index, r1_tag, r1_data, r1_mode} == p_f1)
        else begin errors++; $error("FAIL hold_stable_1: valid=%b expected held request", r1_valid); end
      end
      p_v0 <= r0_valid; p_rdy0 <= r0_ready; p_f0 <= {r0_index, r0_tag, r0_data, r0_mode};
      p_v1 <= r1_valid; p_rdy1 <= r1_ready; p_f1 <= {r1_index, r1_tag, r1_data, r1_mode};
    end
  end

  function automatic cache_req_t rand_req();
    cache_req_t r;
    r.index = 2'($urandom);
    r.tag   = 8'($urandom);
    r.data  = 8'($urandom);
    r.mode  = 1'($urandom);
    return r;
  endfunction

  function automatic logic [7:0] cache_ref(input cache_req_t r);
    return r.mode ? r.data : r.tag;
  endfunction

  task automatic set0(input cache_req_t r, input logic v);
    r0_valid = v; r0_index = r.index; r0_tag = r.tag; r0_data = r.data; r0_mode = r.mode;
  endtask

  task automatic set1(input cache_req_t r, input logic v);
    r1_valid = v; r1_index = r.index; r1_tag = r.tag; r1_data = r.data; r1_mode = r.mode;
  endtask

  // leaves the bench 1 time unit after a rising edge with reset released
  task automatic do_reset();
    cache_req_t z;
    z = '0;
    reset_n = 1'b0;
    set0(z, 1'b0);
    set1(z, 1'b0);
    rsp_ready   = 1'b1;
    r0_valid_3  = 1'b0;
    rsp_ready_3 = 1'b1;
    c_rdata_3   = 8'd0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    cache_req_t a, b, c;
    logic [31:0] outs;
    do_reset();
    @(negedge clock);
    outs = {r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data, c_en, c_index, c_tag, c_data, c_mode};
    checks++;
    if (outs !== 32'd0) begin errors++; $display("FAIL reset_values: got %h expected 0", outs); end
    // start a write and pull reset in the middle of WAIT
    @(posedge clock); #1;
    a = '{index: 2'd3, tag: 8'h3C, data: 8'h77, mode: 1'b1};
    set0(a, 1'b1);
    @(posedge clock); #1 r0_valid = 1'b0;   // now ISSUE
    @(posedge clock);                       // now WAIT
    @(negedge clock);
    checks++;
    if (c_index !== 2'd3) begin errors++; $display("FAIL pre_reset_hold: c_index=%h expected 3", c_index); end
    reset_n = 1'b0;
    #1;
    outs = {r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data, c_en, c_index, c_tag, c_data, c_mode};
    checks++;
    if (outs !== 32'd0) begin errors++; $display("FAIL async_reset: got %h expected 0", outs); end
    @(posedge clock); #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL discarded_rsp: rsp_valid=%b expected 0", rsp_valid); end
    end
    @(posedge clock); #1;
    b = rand_req(); c = rand_req();
    set0(b, 1'b1); set1(c, 1'b1);
    @(negedge clock);
    checks++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      errors++; $display("FAIL regrant_after_reset: readys=%b expected 10", {r0_ready, r1_ready});
    end
  endtask

  task automatic test_single_read();
    cache_req_t a;
    do_reset();
    a = '{index: 2'd2, tag: 8'h05, data: 8'h00, mode: 1'b0};
    set0(a, 1'b1);
    @(negedge clock);
    checks++;
    if (r0_ready !== 1'b1) begin errors++; $display("FAIL read_ready: r0_ready=%b expected 1", r0_ready); end
    @(posedge clock); #1 r0_valid = 1'b0;
    for (int c = 1; c <= 2 + LAT; c++) begin
      @(negedge clock);
      checks++;
      if (c_en !== (c == 1)) begin errors++; $display("FAIL read_c_en cycle %0d: got %b expected %b", c, c_en, (c == 1)); end
      checks++;
      if (rsp_valid !== (c == 2 + LAT)) begin
        errors++; $display("FAIL read_rsp_valid cycle %0d: got %b expected %b", c, rsp_valid, (c == 2 + LAT));
      end
      if (c == 1) begin
        checks++;
        if ({c_index, c_tag, c_mode} !== {2'd2, 8'h05, 1'b0}) begin
          errors++; $display("FAIL read_issue_fields: got %h/%h/%b expected 2/05/0", c_index, c_tag, c_mode);
        end
      end
      @(posedge clock); #1;
    end
    // the loop ends just past the handshake edge of the response cycle
    @(negedge clock);
    checks++;
    if ({rsp_id, rsp_data} !== {1'b0, cache_ref(a)}) begin
      errors++; $display("FAIL read_rsp_data: id=%b data=%h expected 0/%h", rsp_id, rsp_data, cache_ref(a));
    end
  endtask

  task automatic test_write_echo();
    cache_req_t a;
    bit seen;
    do_reset();
    a = '{index: 2'd1, tag: 8'h00, data: 8'hA5, mode: 1'b1};
    set1(a, 1'b1);
    @(negedge clock);
    checks++;
    if ({r0_ready, r1_ready} !== 2'b01) begin errors++; $display("FAIL write_ready: readys=%b expected 01", {r0_ready, r1_ready}); end
    @(posedge clock); #1 r1_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({c_en, c_mode, c_data, c_index} !== {1'b1, 1'b1, 8'hA5, 2'd1}) begin
      errors++; $display("FAIL write_issue: en=%b mode=%b data=%h idx=%h expected 1/1/a5/1", c_en, c_mode, c_data, c_index);
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL write_rsp_timeout: got no rsp_valid expected one"); end
    else if ({rsp_id, rsp_data} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL write_rsp: id=%b data=%h expected 1/a5", rsp_id, rsp_data);
    end
  endtask

  task automatic test_conflict();
    cache_req_t q0, q1;
    exp_rsp_t exp_q[$];
    exp_rsp_t e;
    bit last;
    bit hs0, hs1;
    int n;
    do_reset();
    q0 = rand_req(); q1 = rand_req();
    set0(q0, 1'b1); set1(q1, 1'b1);
    last = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      @(negedge clock);
      hs0 = r0_valid && r0_ready;
      hs1 = r1_valid && r1_ready;
      if (hs0 || hs1) begin
        bit w;
        w = RR ? ~last : 1'b0;
        checks++;
        if (hs0 && hs1) begin errors++; $display("FAIL conflict_onehot: both readys high expected one"); end
        checks++;
        if (hs1 !== w) begin errors++; $display("FAIL conflict_grant %0d: got port %0d expected port %0d", n, hs1, w); end
        last = w;
        e.id = w;
        e.data = w ? cache_ref(q1) : cache_ref(q0);
        exp_q.push_back(e);
        n++;
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL conflict_rsp: got unexpected response expected none"); end
        else begin
          e = exp_q.pop_front();
          if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
            errors++; $display("FAIL conflict_rsp: id=%b data=%h expected %b/%h", rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
      @(posedge clock); #1;
      if (hs0) begin q0 = rand_req(); set0(q0, 1'b1); end
      if (hs1) begin q1 = rand_req(); set1(q1, 1'b1); end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL conflict_timeout: got %0d grants expected 4", n); end
  endtask

  task automatic test_backpressure();
    cache_req_t a, b, c;
    bit seen, w;
    do_reset();
    rsp_ready = 1'b0;
    a = rand_req();
    set0(a, 1'b1);
    @(posedge clock); #1;
    b = rand_req(); c = rand_req();
    set0(b, 1'b1); set1(c, 1'b1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_timeout: got no rsp_valid expected one"); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, r0_ready, r1_ready} !== {1'b1, 1'b0, cache_ref(a), 2'b00}) begin
        errors++; $display("FAIL bp_hold %0d: v=%b id=%b data=%h rdy=%b%b expected 1/0/%h/00",
                           k, rsp_valid, rsp_id, rsp_data, r0_ready, r1_ready, cache_ref(a));
      end
    end
    @(posedge clock); #1 rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({rsp_valid, rsp_data, r0_ready, r1_ready} !== {1'b1, cache_ref(a), 2'b00}) begin
      errors++; $display("FAIL bp_handshake: v=%b data=%h rdy=%b%b expected 1/%h/00",
                         rsp_valid, rsp_data, r0_ready, r1_ready, cache_ref(a));
    end
    @(posedge clock); #1;
    @(negedge clock);
    w = RR ? 1'b1 : 1'b0;   // port 0 won last, so round-robin hands the conflict to port 1
    checks++;
    if ({r0_ready, r1_ready} !== {~w, w}) begin
      errors++; $display("FAIL bp_next_accept: readys=%b%b expected %b%b", r0_ready, r1_ready, ~w, w);
    end
  endtask

  task automatic test_lat3();
    logic [7:0] v [0:15];
    do_reset();
    rsp_ready_3 = 1'b0;
    r0_valid_3  = 1'b1;
    c_rdata_3   = 8'($urandom);
    v[0] = c_rdata_3;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      if (c == 0) begin
        checks++;
        if (r0_ready_3 !== 1'b1) begin errors++; $display("FAIL lat3_ready: got %b expected 1", r0_ready_3); end
      end
      checks++;
      if (rsp_valid_3 !== (c >= 2 + LAT3)) begin
        errors++; $display("FAIL lat3_rsp_valid cycle %0d: got %b expected %b", c, rsp_valid_3, (c >= 2 + LAT3));
      end
      if (c >= 2 + LAT3) begin
        checks++;
        if ({rsp_id_3, rsp_data_3} !== {1'b0, v[1 + LAT3]}) begin
          errors++; $display("FAIL lat3_rsp_data cycle %0d: got %h expected %h", c, rsp_data_3, v[1 + LAT3]);
        end
      end
      @(posedge clock); #1;
      if (c == 0) r0_valid_3 = 1'b0;
      c_rdata_3 = 8'($urandom);
      v[c + 1] = c_rdata_3;
    end
  endtask

  task automatic test_random();
    cache_req_t q0, q1, cur;
    bit busy, last, w, hs, exp_r0, exp_r1, exp_rv;
    int acc;
    logic [7:0] exp_data;
    logic exp_id;
    do_reset();
    busy = 0; last = 1; acc = 0; exp_id = 0; exp_data = 0; cur = '0;
    q0 = rand_req(); q1 = rand_req();
    set0(q0, 1'($urandom)); set1(q1, 1'($urandom));
    rsp_ready = 1'($urandom);
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (r0_valid && r1_valid) w = RR ? ~last : 1'b0;
      else                      w = r1_valid;
      exp_r0 = !busy && r0_valid && !w;
      exp_r1 = !busy && r1_valid && w;
      checks++;
      if ({r0_ready, r1_ready} !== {exp_r0, exp_r1}) begin
        errors++; $display("FAIL rand_ready cyc %0d: got %b%b expected %b%b", c, r0_ready, r1_ready, exp_r0, exp_r1);
      end
      checks++;
      if (c_en !== (busy && c == acc + 1)) begin
        errors++; $display("FAIL rand_c_en cyc %0d: got %b expected %b", c, c_en, (busy && c == acc + 1));
      end
      if (busy && c == acc + 1) begin
        checks++;
        if ({c_index, c_tag, c_data, c_mode} !== {cur.index, cur.tag, cur.data, cur.mode}) begin
          errors++; $display("FAIL rand_issue cyc %0d: got %h/%h/%h/%b expected %h/%h/%h/%b", c,
                             c_index, c_tag, c_data, c_mode, cur.index, cur.tag, cur.data, cur.mode);
        end
      end
      exp_rv = busy && (c >= acc + 2 + LAT);
      checks++;
      if (rsp_valid !== exp_rv) begin
        errors++; $display("FAIL rand_rsp_valid cyc %0d: got %b expected %b", c, rsp_valid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if ({rsp_id, rsp_data} !== {exp_id, exp_data}) begin
          errors++; $display("FAIL rand_rsp cyc %0d: id=%b data=%h expected %b/%h", c, rsp_id, rsp_data, exp_id, exp_data);
        end
      end
      hs = exp_r0 || exp_r1;
      if (hs) begin
        busy = 1; acc = c; last = w; exp_id = w;
        cur = w ? q1 : q0;
        exp_data = cache_ref(cur);
      end else if (exp_rv && rsp_ready) begin
        busy = 0;
      end
      @(posedge clock); #1;
      if ((hs && !w) || !r0_valid) begin q0 = rand_req(); set0(q0, 1'($urandom)); end
      if ((hs && w) || !r1_valid)  begin q1 = rand_req(); set1(q1, 1'($urandom)); end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_echo();
    test_conflict();
    test_backpressure();
    test_lat3();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
